sync_asym_fifo: RTL and testbench

- Single-clock FIFO with independent, power-of-2-related write and read widths.
- Supports both up-conversion (narrow write, wide read) and down-conversion (wide write, narrow read).
- Provides full/empty flags, water levels, programmable thresholds and overflow/underflow error pulses.
- Sits between a narrow pixel/byte stream and the wide DDR3 AXI burst side inside one clock domain. It is the single-clock, bidirectional-ratio successor of the asymmetric dual-port RAM.

---
 rtl/sync_asym_fifo.sv | 189 ++++++++++++++++++
 tb/tb_sync_asym_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_asym_fifo.sv
// Single-clock asymmetric FIFO.
// Storage is held in units of min(WR_WIDTH, RD_WIDTH) bits. The write side
// deposits WR_U units per accepted write and the read side removes RD_U units
// per accepted read. This allows both up-conversion (narrow in, wide out) and
// down-conversion (wide in, narrow out). Packing is little-endian: the unit
// written first ends up in the lowest bits of a wide word.
module sync_asym_fifo #(
    parameter int WR_WIDTH      = 8,
    parameter int RD_WIDTH      = 32,
    parameter int DEPTH         = 64,
    parameter int ADDR_WIDTH    = 6,
    parameter int PROG_FULL_TH  = 48,
    parameter int PROG_EMPTY_TH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // write side
    input  logic                  wr_en,
    input  logic [WR_WIDTH-1:0]   wr_data,
    output logic                  wr_full,
    output logic                  prog_full,
    output logic                  wr_overflow,
    output logic [ADDR_WIDTH:0]   wr_water_level,
    // read side
    input  logic                  rd_en,
    output logic [RD_WIDTH-1:0]   rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  prog_empty,
    output logic                  rd_underflow,
    output logic [ADDR_WIDTH:0]   rd_water_level
);

    // ------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------
    localparam int UNIT  = (WR_WIDTH < RD_WIDTH) ? WR_WIDTH : RD_WIDTH;
    localparam int WR_U  = WR_WIDTH / UNIT;
    localparam int RD_U  = RD_WIDTH / UNIT;
    localparam int RATIO = WR_U * RD_U;          // one of WR_U / RD_U is 1
    localparam int WR_SH = $clog2(WR_U);
    localparam int RD_SH = $clog2(RD_U);
    localparam int PW    = ADDR_WIDTH + 1;

    localparam logic [PW-1:0] WR_STEP  = PW'(WR_U);
    localparam logic [PW-1:0] RD_STEP  = PW'(RD_U);
    localparam logic [31:0]   DEPTH_W  = 32'(DEPTH);
    localparam logic [31:0]   WR_U_W   = 32'(WR_U);
    localparam logic [31:0]   RD_U_W   = 32'(RD_U);
    localparam logic [31:0]   PF_TH_W  = 32'(PROG_FULL_TH);
    localparam logic [31:0]   PE_TH_W  = 32'(PROG_EMPTY_TH);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if ((WR_WIDTH % UNIT) != 0 || (RD_WIDTH % UNIT) != 0 ||
            (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
            $error("sync_asym_fifo: WR_WIDTH and RD_WIDTH must differ by a power of 2");
        end
        if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
            $error("sync_asym_fifo: DEPTH must equal 2**ADDR_WIDTH");
        end
        if ((DEPTH % RATIO) != 0) begin : g_bad_multiple
            $error("sync_asym_fifo: DEPTH must be a multiple of the width ratio");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [UNIT-1:0]       mem [DEPTH];
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [PW-1:0]         wr_ptr_next;
    logic [PW-1:0]         rd_ptr_next;
    logic [RD_WIDTH-1:0]   rd_data_reg;
    logic                  rd_valid_reg;
    logic                  wr_overflow_reg;
    logic                  rd_underflow_reg;

    logic [PW-1:0]         cnt;
    logic [31:0]           cnt_w;
    logic [31:0]           free_w;
    logic                  wr_accept;
    logic                  rd_accept;

    logic [UNIT-1:0]       wr_unit [WR_U];
    logic [ADDR_WIDTH-1:0] wr_addr [WR_U];
    logic [ADDR_WIDTH-1:0] rd_addr [RD_U];
    logic [RD_WIDTH-1:0]   rd_word;

    // ------------------------------------------------------------------
    // Occupancy, flags and levels: all derived from the registered
    // pointers so they describe the FIFO as it was at the start of the
    // cycle. Same-cycle requests never influence each other's acceptance.
    // ------------------------------------------------------------------
    assign cnt    = wr_ptr_reg - rd_ptr_reg;
    assign cnt_w  = 32'(cnt);
    assign free_w = DEPTH_W - cnt_w;

    assign wr_full        = (free_w < WR_U_W);
    assign rd_empty       = (cnt_w < RD_U_W);
    assign prog_full      = (cnt_w >= PF_TH_W);
    assign prog_empty     = (cnt_w <= PE_TH_W);
    assign wr_water_level = cnt >> WR_SH;
    assign rd_water_level = cnt >> RD_SH;

    assign wr_accept = wr_en & ~wr_full;
    assign rd_accept = rd_en & ~rd_empty;

    // ------------------------------------------------------------------
    // Unit slicing. Pointers only ever advance in multiples of their own
    // step and DEPTH is a multiple of both steps, so a multi-unit access
    // never wraps across the array end; plain low-bit addressing suffices.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WR_U; gi++) begin : g_wr_slice
            assign wr_unit[gi] = wr_data[gi*UNIT +: UNIT];
            assign wr_addr[gi] = wr_ptr_reg[ADDR_WIDTH-1:0] + ADDR_WIDTH'(gi);
        end
        for (genvar gi = 0; gi < RD_U; gi++) begin : g_rd_slice
            assign rd_addr[gi] = rd_ptr_reg[ADDR_WIDTH-1:0] + ADDR_WIDTH'(gi);
            assign rd_word[gi*UNIT +: UNIT] = mem[rd_addr[gi]];
        end
    endgenerate

    // Next pointer values for accepted requests.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (wr_accept) begin
            wr_ptr_next = wr_ptr_reg + WR_STEP;
        end
        if (rd_accept) begin
            rd_ptr_next = rd_ptr_reg + RD_STEP;
        end
    end

    // Storage write; contents are left alone by reset (pointers make them unreachable).
    always_ff @(posedge clk) begin
        if (rst_n && wr_accept) begin
            for (int k = 0; k < WR_U; k++) begin
                mem[wr_addr[k]] <= wr_unit[k];
            end
        end
    end

    // Pointer update; both sides advance on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Registered read data and valid strobe; data holds when no read is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_accept;
            if (rd_accept) begin
                rd_data_reg <= rd_word;
            end
        end
    end

    // One-cycle error pulses for refused requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_overflow_reg  <= 1'b0;
            rd_underflow_reg <= 1'b0;
        end else begin
            wr_overflow_reg  <= wr_en & wr_full;
            rd_underflow_reg <= rd_en & rd_empty;
        end
    end

    assign rd_data      = rd_data_reg;
    assign rd_valid     = rd_valid_reg;
    assign wr_overflow  = wr_overflow_reg;
    assign rd_underflow = rd_underflow_reg;

endmodule

// File: tb/tb_sync_asym_fifo.sv
// Testbench for sync_asym_fifo: one up-converting (8->32) and one
// down-converting (32->8) instance, a byte-queue reference model per
// instance, a read scoreboard, a vector table for the partial-word case and
// hand-written sequences for full/empty/wrap/reset corners.
module tb_sync_asym_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // up-conversion instance signals
    logic        a_wr_en, a_rd_en;
    logic [7:0]  a_wr_data;
    logic [31:0] a_rd_data;
    logic        a_wr_full, a_prog_full, a_wr_overflow, a_rd_valid;
    logic        a_rd_empty, a_prog_empty, a_rd_underflow;
    logic [6:0]  a_wr_water_level, a_rd_water_level;

    // down-conversion instance signals
    logic        b_wr_en, b_rd_en;
    logic [31:0] b_wr_data;
    logic [7:0]  b_rd_data;
    logic        b_wr_full, b_prog_full, b_wr_overflow, b_rd_valid;
    logic        b_rd_empty, b_prog_empty, b_rd_underflow;
    logic [6:0]  b_wr_water_level, b_rd_water_level;

    sync_asym_fifo #(
        .WR_WIDTH(8), .RD_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(6),
        .PROG_FULL_TH(48), .PROG_EMPTY_TH(8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .wr_en(a_wr_en), .wr_data(a_wr_data), .wr_full(a_wr_full),
        .prog_full(a_prog_full), .wr_overflow(a_wr_overflow),
        .wr_water_level(a_wr_water_level),
        .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .rd_empty(a_rd_empty), .prog_empty(a_prog_empty),
        .rd_underflow(a_rd_underflow), .rd_water_level(a_rd_water_level)
    );

    sync_asym_fifo #(
        .WR_WIDTH(32), .RD_WIDTH(8), .DEPTH(64), .ADDR_WIDTH(6),
        .PROG_FULL_TH(48), .PROG_EMPTY_TH(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(b_wr_en), .wr_data(b_wr_data), .wr_full(b_wr_full),
        .prog_full(b_prog_full), .wr_overflow(b_wr_overflow),
        .wr_water_level(b_wr_water_level),
        .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .rd_empty(b_rd_empty), .prog_empty(b_prog_empty),
        .rd_underflow(b_rd_underflow), .rd_water_level(b_rd_water_level)
    );

    int checks = 0;
    int passes = 0;

    // reference models: stored bytes, oldest first
    logic [7:0]  ma[$];
    logic [7:0]  mb[$];
    // scoreboards of expected read words
    logic [31:0] sba[$];
    logic [7:0]  sbb[$];
    logic [31:0] exp_rd_a;
    logic [7:0]  exp_rd_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock of the 8->32 instance, checked against the model.
    task automatic cyc_a(input bit we, input logic [7:0] wd, input bit re);
        int n;
        bit acc_w, acc_r;
        n = ma.size();
        a_wr_en = we; a_wr_data = wd; a_rd_en = re;
        #1;
        chk("a_wr_full",   a_wr_full,        64'((64 - n) < 1));
        chk("a_rd_empty",  a_rd_empty,       64'(n < 4));
        chk("a_wr_level",  a_wr_water_level, 64'(n));
        chk("a_rd_level",  a_rd_water_level, 64'(n / 4));
        chk("a_prog_full", a_prog_full,      64'(n >= 48));
        chk("a_prog_empty", a_prog_empty,    64'(n <= 8));
        acc_w = we && (n < 64);
        acc_r = re && (n >= 4);
        if (acc_r) begin
            sba.push_back({ma[3], ma[2], ma[1], ma[0]});
            repeat (4) void'(ma.pop_front());
        end
        if (acc_w) ma.push_back(wd);
        @(posedge clk); #1;
        chk("a_wr_overflow",  a_wr_overflow,  64'(we && !acc_w));
        chk("a_rd_underflow", a_rd_underflow, 64'(re && !acc_r));
        chk("a_rd_valid",     a_rd_valid,     64'(acc_r));
        if (acc_r) exp_rd_a = sba.pop_front();
        chk("a_rd_data", a_rd_data, exp_rd_a);
    endtask

    // One clock of the 32->8 instance, checked against the model.
    task automatic cyc_b(input bit we, input logic [31:0] wd, input bit re);
        int n;
        bit acc_w, acc_r;
        n = mb.size();
        b_wr_en = we; b_wr_data = wd; b_rd_en = re;
        #1;
        chk("b_wr_full",   b_wr_full,        64'((64 - n) < 4));
        chk("b_rd_empty",  b_rd_empty,       64'(n < 1));
        chk("b_wr_level",  b_wr_water_level, 64'(n / 4));
        chk("b_rd_level",  b_rd_water_level, 64'(n));
        chk("b_prog_full", b_prog_full,      64'(n >= 48));
        chk("b_prog_empty", b_prog_empty,    64'(n <= 8));
        acc_w = we && ((64 - n) >= 4);
        acc_r = re && (n >= 1);
        if (acc_r) sbb.push_back(mb.pop_front());
        if (acc_w) for (int k = 0; k < 4; k++) mb.push_back(wd[8*k +: 8]);
        @(posedge clk); #1;
        chk("b_wr_overflow",  b_wr_overflow,  64'(we && !acc_w));
        chk("b_rd_underflow", b_rd_underflow, 64'(re && !acc_r));
        chk("b_rd_valid",     b_rd_valid,     64'(acc_r));
        if (acc_r) exp_rd_b = sbb.pop_front();
        chk("b_rd_data", b_rd_data, 64'(exp_rd_b));
    endtask

    typedef struct {
        bit          we;
        logic [7:0]  wd;
        bit          re;
        bit          e_empty;   // before the edge
        int          e_rlev;    // before the edge
        bit          e_valid;   // after the edge
        bit          e_unf;     // after the edge
        logic [31:0] e_data;    // after the edge
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [31:0] pat;
        // partial-word vectors on the 8->32 instance, starting right after reset
        tbl[0] = '{1'b1, 8'hA0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 8'hA1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 8'hA2, 1'b0, 1'b1, 0, 1'b0, 1'b0, 32'h0};
        tbl[3] = '{1'b1, 8'hA3, 1'b0, 1'b1, 0, 1'b0, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 32'h0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b0, 32'hA3A2A1A0};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 32'hA3A2A1A0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1, 32'hA3A2A1A0};

        rst_n = 1'b0;
        a_wr_en = 0; a_rd_en = 0; a_wr_data = '0;
        b_wr_en = 0; b_rd_en = 0; b_wr_data = '0;
        exp_rd_a = '0; exp_rd_b = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        chk("rst_a_rd_empty",  a_rd_empty, 1);
        chk("rst_a_wr_full",   a_wr_full, 0);
        chk("rst_a_prog_empty", a_prog_empty, 1);
        chk("rst_a_prog_full", a_prog_full, 0);
        chk("rst_a_levels",    {a_wr_water_level, a_rd_water_level}, 0);
        chk("rst_a_rd_data",   a_rd_data, 0);
        chk("rst_a_rd_valid",  a_rd_valid, 0);
        chk("rst_b_rd_empty",  b_rd_empty, 1);
        chk("rst_b_wr_full",   b_wr_full, 0);

        // partial word table
        for (int i = 0; i < 8; i++) begin
            a_wr_en = tbl[i].we; a_wr_data = tbl[i].wd; a_rd_en = tbl[i].re;
            #1;
            chk("tbl_rd_empty", a_rd_empty, 64'(tbl[i].e_empty));
            chk("tbl_rd_level", a_rd_water_level, 64'(tbl[i].e_rlev));
            @(posedge clk); #1;
            chk("tbl_rd_valid",  a_rd_valid, 64'(tbl[i].e_valid));
            chk("tbl_underflow", a_rd_underflow, 64'(tbl[i].e_unf));
            chk("tbl_rd_data",   a_rd_data, tbl[i].e_data);
        end
        exp_rd_a = 32'hA3A2A1A0;

        // fill with 0x00..0x3F
        for (int i = 0; i < 64; i++) cyc_a(1'b1, 8'(i), 1'b0);
        chk("fill_wr_full",   a_wr_full, 1);
        chk("fill_wr_level",  a_wr_water_level, 64);
        chk("fill_rd_level",  a_rd_water_level, 16);
        chk("fill_prog_full", a_prog_full, 1);
        cyc_a(1'b1, 8'hFF, 1'b0);            // refused 65th write
        for (int i = 0; i < 16; i++) begin
            cyc_a(1'b0, 8'h00, 1'b1);
            chk("drain_word", a_rd_data,
                {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        end
        cyc_a(1'b0, 8'h00, 1'b0);
        chk("drain_empty", a_rd_empty, 1);
        cyc_a(1'b0, 8'h00, 1'b1);            // underflow, data holds
        chk("unf_hold", a_rd_data, 32'h3F3E3D3C);

        // simultaneous write and read at full
        for (int i = 0; i < 64; i++) cyc_a(1'b1, 8'(i + 64), 1'b0);
        cyc_a(1'b1, 8'hEE, 1'b1);
        chk("simul_level", a_wr_water_level, 60);
        chk("simul_not_full", a_wr_full, 0);
        for (int i = 0; i < 15; i++) cyc_a(1'b0, 8'h00, 1'b1);

        // three full fill/drain passes across pointer wrap
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 64; i++) cyc_a(1'b1, 8'(p * 64 + i + 7), 1'b0);
            for (int i = 0; i < 16; i++) cyc_a(1'b0, 8'h00, 1'b1);
        end

        // reset with 20 bytes stored, requests asserted during reset
        for (int i = 0; i < 20; i++) cyc_a(1'b1, 8'(128 + i), 1'b0);
        rst_n = 1'b0; a_wr_en = 1; a_wr_data = 8'h55; a_rd_en = 1;
        @(posedge clk); #1;
        rst_n = 1'b1; a_wr_en = 0; a_rd_en = 0;
        ma.delete(); sba.delete(); exp_rd_a = '0;
        chk("mrst_rd_empty",  a_rd_empty, 1);
        chk("mrst_wr_full",   a_wr_full, 0);
        chk("mrst_prog",      {a_prog_empty, a_prog_full}, 2'b10);
        chk("mrst_levels",    {a_wr_water_level, a_rd_water_level}, 0);
        chk("mrst_rd_data",   a_rd_data, 0);
        chk("mrst_rd_valid",  a_rd_valid, 0);
        chk("mrst_errors",    {a_wr_overflow, a_rd_underflow}, 0);
        for (int i = 0; i < 4; i++) cyc_a(1'b1, 8'(8'h11 + i), 1'b0);
        cyc_a(1'b0, 8'h00, 1'b1);
        chk("mrst_new_word", a_rd_data, 32'h14131211);

        // down-conversion
        pat = 32'hDDCCBBAA;
        cyc_b(1'b1, pat, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc_b(1'b0, 32'h0, 1'b1);
            chk("down_byte", b_rd_data, 64'(pat[8*k +: 8]));
        end
        cyc_b(1'b0, 32'h0, 1'b0);
        chk("down_empty", b_rd_empty, 1);
        cyc_b(1'b0, 32'h0, 1'b1);            // underflow
        for (int i = 0; i < 17; i++)
            cyc_b(1'b1, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 1'b0);
        for (int i = 0; i < 64; i++) begin
            cyc_b(1'b0, 32'h0, 1'b1);
            chk("down_seq", b_rd_data, 64'(8'(i)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
